// File: rtl/sipo_comma_align.sv
// sipo_comma_align: serial-to-parallel deserialiser with 8b/10b comma word alignment.
// The HUNT/CHECK/LOCKED state machine finds the word boundary from K28.5 commas in
// either running disparity. It emits a one-cycle RxValid strobe for each aligned word.
// Optional build macro SIPO_ALIGN_STATS_EN adds the 16-bit Realign_Count output.
module sipo_comma_align #(
    parameter int unsigned           WORD_W    = 10,
    parameter bit                    LSB_FIRST = 1'b1,
    parameter logic [WORD_W-1:0]     COMMA_P   = 10'b0101111100,
    parameter logic [WORD_W-1:0]     COMMA_N   = 10'b1010000011,
    parameter int unsigned           LOCK_CNT  = 3,
    parameter int unsigned           LOSS_CNT  = 4
) (
    input  logic              BitCLK,
    input  logic              Reset,
    input  logic              Serial,
    output logic [WORD_W-1:0] RxParallel,
    output logic              RxValid,
    output logic              Comma_Det,
    output logic              Locked,
    output logic              Align_Event
`ifdef SIPO_ALIGN_STATS_EN
    ,
    output logic [15:0]       Realign_Count
`endif
);

    localparam int unsigned CNT_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam int unsigned PW      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CW-1:0] LOCK_C  = CW'(LOCK_CNT);
    localparam logic [CW-1:0] LOSS_C  = CW'(LOSS_CNT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PH_LAST = PW'(WORD_W - 1);
    localparam logic [PW-1:0] PH_ONE  = PW'(1);

    localparam logic [1:0] StHunt   = 2'd0;
    localparam logic [1:0] StCheck  = 2'd1;
    localparam logic [1:0] StLocked = 2'd2;

    logic [WORD_W-1:0] r_sh;
    logic [PW-1:0]     r_ph;
    logic [1:0]        r_state;
    logic [CW-1:0]     r_good;
    logic [CW-1:0]     r_bad;
    logic [WORD_W-1:0] r_rx_parallel;
    logic              r_rx_valid;
    logic              r_comma_det;
    logic              r_locked;
    logic              r_align_event;

    logic [WORD_W-1:0] w_win;
    logic              w_is_comma;
    logic              w_boundary;
    logic [PW-1:0]     w_ph_nxt;
    logic [1:0]        w_state_nxt;
    logic [CW-1:0]     w_good_nxt;
    logic [CW-1:0]     w_bad_nxt;
    logic              w_emit;
    logic              w_align;
    logic              w_loss;

    // Window with the current serial bit already inserted, plus comma/boundary decode.
    always_comb begin
        if (LSB_FIRST) begin
            w_win = {Serial, r_sh[WORD_W-1:1]};
        end else begin
            w_win = {r_sh[WORD_W-2:0], Serial};
        end
        w_is_comma = (w_win == COMMA_P) || (w_win == COMMA_N);
        w_boundary = (r_ph == PH_LAST);
    end

    // Lock state machine: next state, counters, emit and realign decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_bad_nxt   = r_bad;
        w_emit      = 1'b0;
        w_align     = 1'b0;
        w_loss      = 1'b0;
        w_ph_nxt    = w_boundary ? '0 : r_ph + PH_ONE;

        case (r_state)
            StHunt: begin
                if (w_is_comma) begin
                    w_emit      = 1'b1;
                    w_align     = 1'b1;
                    w_good_nxt  = CNT_ONE;
                    w_state_nxt = (LOCK_CNT == 1) ? StLocked : StCheck;
                end
            end
            StCheck: begin
                if (w_boundary) begin
                    w_emit = 1'b1;
                    if (w_is_comma) begin
                        if (r_good < LOCK_C) begin
                            w_good_nxt = r_good + CNT_ONE;
                        end
                        if ((r_good + CNT_ONE) >= LOCK_C) begin
                            w_state_nxt = StLocked;
                        end
                    end
                end else if (w_is_comma) begin
                    // Comma off the current boundary: restart alignment on it.
                    w_emit     = 1'b1;
                    w_align    = 1'b1;
                    w_good_nxt = CNT_ONE;
                end
            end
            StLocked: begin
                if (w_boundary) begin
                    w_emit = 1'b1;
                    if (w_is_comma) begin
                        w_bad_nxt = '0;
                    end
                end else if (w_is_comma) begin
                    // Misaligned comma while locked: count it, never realign here.
                    if ((r_bad + CNT_ONE) >= LOSS_C) begin
                        w_state_nxt = StHunt;
                        w_bad_nxt   = '0;
                        w_good_nxt  = '0;
                        w_loss      = 1'b1;
                    end else begin
                        w_bad_nxt = r_bad + CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = StHunt;
                w_good_nxt  = '0;
                w_bad_nxt   = '0;
            end
        endcase

        if (w_align) begin
            w_ph_nxt = '0;
        end
    end

    // State, shift register and registered outputs.
    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            r_sh          <= '0;
            r_ph          <= '0;
            r_state       <= StHunt;
            r_good        <= '0;
            r_bad         <= '0;
            r_rx_parallel <= '0;
            r_rx_valid    <= 1'b0;
            r_comma_det   <= 1'b0;
            r_locked      <= 1'b0;
            r_align_event <= 1'b0;
        end else begin
            r_sh          <= w_win;
            r_ph          <= w_ph_nxt;
            r_state       <= w_state_nxt;
            r_good        <= w_good_nxt;
            r_bad         <= w_bad_nxt;
            r_rx_valid    <= w_emit;
            r_comma_det   <= w_emit & w_is_comma;
            r_locked      <= (w_state_nxt == StLocked);
            r_align_event <= w_align;
            if (w_emit) begin
                r_rx_parallel <= w_win;
            end
        end
    end

    assign RxParallel  = r_rx_parallel;
    assign RxValid     = r_rx_valid;
    assign Comma_Det   = r_comma_det;
    assign Locked      = r_locked;
    assign Align_Event = r_align_event;

`ifdef SIPO_ALIGN_STATS_EN
    logic [15:0] r_realign_cnt;

    // Saturating count of boundary (re)sets and lock losses.
    always_ff @(posedge BitCLK) begin
        if (Reset) begin
            r_realign_cnt <= '0;
        end else if ((w_align || w_loss) && (r_realign_cnt != 16'hFFFF)) begin
            r_realign_cnt <= r_realign_cnt + 16'd1;
        end
    end

    assign Realign_Count = r_realign_cnt;
`endif

endmodule
